// File: rtl/bench_bist_ctrl_if.sv
// Signal bundle between the BIST controller (master) and the bench plus benchmark netlist (slave).
interface bench_bist_ctrl_if #(
    parameter int NUM_REGS = 21,
    parameter int NUM_IN   = 3,
    parameter int NUM_OUT  = 6
);
    logic                start;
    logic [NUM_REGS-1:0] init_state;
    logic [15:0]         golden_sig;
    logic                scan_en;
    logic                scan_si;
    logic                scan_so;
    logic [NUM_IN-1:0]   dut_inputs;
    logic [NUM_OUT-1:0]  dut_outputs;
    logic                busy;
    logic                done;
    logic                pass;
    logic [15:0]         signature;

    modport master (
        input  start, init_state, golden_sig, scan_so, dut_outputs,
        output scan_en, scan_si, dut_inputs, busy, done, pass, signature
    );

    modport slave (
        output start, init_state, golden_sig, scan_so, dut_outputs,
        input  scan_en, scan_si, dut_inputs, busy, done, pass, signature
    );
endinterface

// File: rtl/bench_bist_ctrl.sv
// Scan-load, LFSR-driven run, scan-unload into a MISR, then compare against golden_sig.
// Latency start->done is 2*NUM_REGS+NUM_PATTERNS cycles after the start edge; no backpressure, start ignored unless idle.
module bench_bist_ctrl #(
    parameter int          NUM_REGS     = 21,
    parameter int          NUM_IN       = 3,
    parameter int          NUM_OUT      = 6,
    parameter int          NUM_PATTERNS = 64,
    parameter logic [15:0] LFSR_SEED    = 16'h0001
) (
    input logic             clock,
    input logic             reset,
    bench_bist_ctrl_if.master bus
);
    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] POLY      = 16'hB400;
    localparam int          CNT_MAX   = (NUM_REGS > NUM_PATTERNS) ? NUM_REGS : NUM_PATTERNS;
    localparam int          CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] REGS_LAST = CNT_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] PAT_LAST  = CNT_W'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_UNLOAD, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REGS-1:0] shreg_q, shreg_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [15:0]         misr_q, misr_d;
    logic                scan_en_q, scan_en_d;
    logic                scan_si_q, scan_si_d;
    logic [NUM_IN-1:0]   din_q, din_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;

    function automatic logic [15:0] shift16(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? POLY : 16'h0000);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    cnt_d   = REGS_LAST;
                    shreg_d = bus.init_state;
                    lfsr_d  = SEED;
                    misr_d  = 16'h0000;
                    pass_d  = 1'b0;
                end
            end
            S_LOAD: begin
                shreg_d = shreg_q << 1;
                if (cnt_q == '0) begin
                    state_d = S_RUN;
                    cnt_d   = PAT_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RUN: begin
                lfsr_d = shift16(lfsr_q);
                misr_d = shift16(misr_q) ^ 16'(bus.dut_outputs);
                if (cnt_q == '0) begin
                    state_d = S_UNLOAD;
                    cnt_d   = REGS_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_UNLOAD: begin
                misr_d = shift16(misr_q) ^ {15'b0, bus.scan_so};
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                pass_d  = (misr_q == bus.golden_sig);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so derive them from the state being entered.
        scan_en_d = (state_d == S_LOAD) || (state_d == S_UNLOAD);
        scan_si_d = (state_d == S_LOAD) && shreg_d[NUM_REGS-1];
        din_d     = (state_d == S_RUN) ? lfsr_d[NUM_IN-1:0] : '0;
        busy_d    = scan_en_d || (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            lfsr_q    <= SEED;
            misr_q    <= 16'h0000;
            scan_en_q <= 1'b0;
            scan_si_q <= 1'b0;
            din_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            scan_en_q <= scan_en_d;
            scan_si_q <= scan_si_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign bus.scan_en    = scan_en_q;
    assign bus.scan_si    = scan_si_q;
    assign bus.dut_inputs = din_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.signature  = misr_q;
endmodule
